// File: rtl/rv_mc_core.sv
// rv_mc_core: multi-cycle RV32I-subset core with one shared req/ack memory port.
// Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> WB; EBREAK parks
// the core in HALT, bad encodings or misaligned addresses park it in ERR.
// Optional feature macro: RV_MC_BRANCH_EN adds BEQ, BNE and JAL.
module rv_mc_core #(
    parameter int                ADDR_W   = 12,
    parameter int                NREGS    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    localparam int         RIDX_W = (NREGS > 16) ? 5 : 4;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;
`ifdef RV_MC_BRANCH_EN
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
`endif

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_ERR
    } state_t;

    state_t            state_r, state_next_s;
    logic [ADDR_W-1:0] pc_r, npc_r, mem_addr_r;
    logic [31:0]       ir_r, a_r, b_r, res_r, mem_wdata_r;
    logic [31:0]       rf_r [NREGS];
    logic              mem_req_r, mem_we_r, retire_r, halted_r, illegal_r;

    logic [6:0]        opcode_s, f7_s;
    logic [4:0]        rd_s, rs1_s, rs2_s;
    logic [2:0]        f3_s;
    logic [31:0]       imm_i_s, imm_s_s, op_imm_s, alu_s;
    logic [ADDR_W-1:0] ea_s, pc_plus4_s, npc_s;
    logic              dec_bad_s, is_ebreak_s, is_lw_s, is_sw_s, misalign_s, wb_en_s;

    // Register index beyond the implemented register file (RV32E has 16)
    function automatic logic reg_bad(input logic [4:0] idx);
        return (idx > 5'(NREGS - 1));
    endfunction

    assign opcode_s   = ir_r[6:0];
    assign rd_s       = ir_r[11:7];
    assign f3_s       = ir_r[14:12];
    assign rs1_s      = ir_r[19:15];
    assign rs2_s      = ir_r[24:20];
    assign f7_s       = ir_r[31:25];
    assign is_lw_s    = (opcode_s == OP_LW);
    assign is_sw_s    = (opcode_s == OP_SW);
    assign imm_i_s    = {{20{ir_r[31]}}, ir_r[31:20]};
    assign imm_s_s    = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
    assign op_imm_s   = is_sw_s ? imm_s_s : imm_i_s;
    assign ea_s       = a_r[ADDR_W-1:0] + op_imm_s[ADDR_W-1:0];
    assign pc_plus4_s = pc_r + {{(ADDR_W-3){1'b0}}, 3'b100};

`ifdef RV_MC_BRANCH_EN
    logic [31:0] imm_b_s, imm_j_s;
    logic        br_taken_s;
    assign imm_b_s    = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
    assign imm_j_s    = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
    assign br_taken_s = f3_s[0] ? (a_r != b_r) : (a_r == b_r);
`endif

    // Decode legality: unsupported opcode/funct combination or register index out of range
    always_comb begin
        dec_bad_s   = 1'b1;
        is_ebreak_s = 1'b0;
        case (opcode_s)
            OP_R: dec_bad_s = !((f7_s == 7'b0000000 && (f3_s == 3'b000 || f3_s == 3'b001 ||
                                  f3_s == 3'b101 || f3_s == 3'b111 || f3_s == 3'b110)) ||
                                (f7_s == 7'b0100000 && f3_s == 3'b000)) ||
                              reg_bad(rd_s) || reg_bad(rs1_s) || reg_bad(rs2_s);
            OP_I: dec_bad_s = !(f3_s == 3'b000 || f3_s == 3'b111 || f3_s == 3'b110) ||
                              reg_bad(rd_s) || reg_bad(rs1_s);
            OP_LW: dec_bad_s = (f3_s != 3'b010) || reg_bad(rd_s) || reg_bad(rs1_s);
            OP_SW: dec_bad_s = (f3_s != 3'b010) || reg_bad(rs1_s) || reg_bad(rs2_s);
            OP_SYS: begin
                is_ebreak_s = (ir_r == 32'h0010_0073);
                dec_bad_s   = (ir_r != 32'h0010_0073);
            end
`ifdef RV_MC_BRANCH_EN
            OP_BR:  dec_bad_s = (f3_s != 3'b000 && f3_s != 3'b001) || reg_bad(rs1_s) || reg_bad(rs2_s);
            OP_JAL: dec_bad_s = reg_bad(rd_s);
`endif
            default: dec_bad_s = 1'b1;
        endcase
    end

    // Execute: ALU result, next PC and alignment check of the computed address
    always_comb begin
        alu_s      = 32'd0;
        npc_s      = pc_plus4_s;
        misalign_s = 1'b0;
        case (opcode_s)
            OP_R: begin
                case ({f7_s[5], f3_s})
                    4'b0000: alu_s = a_r + b_r;
                    4'b1000: alu_s = a_r - b_r;
                    4'b0001: alu_s = a_r << b_r[4:0];
                    4'b0101: alu_s = a_r >> b_r[4:0];
                    4'b0111: alu_s = a_r & b_r;
                    4'b0110: alu_s = a_r | b_r;
                    default: alu_s = 32'd0;
                endcase
            end
            OP_I: begin
                case (f3_s)
                    3'b000:  alu_s = a_r + imm_i_s;
                    3'b111:  alu_s = a_r & imm_i_s;
                    3'b110:  alu_s = a_r | imm_i_s;
                    default: alu_s = 32'd0;
                endcase
            end
            OP_LW, OP_SW: misalign_s = (ea_s[1:0] != 2'b00);
`ifdef RV_MC_BRANCH_EN
            OP_BR: begin
                if (br_taken_s) begin
                    npc_s      = pc_r + imm_b_s[ADDR_W-1:0];
                    misalign_s = (npc_s[1:0] != 2'b00);
                end else begin
                    npc_s      = pc_plus4_s;
                end
            end
            OP_JAL: begin
                alu_s      = {{(32-ADDR_W){1'b0}}, pc_plus4_s};
                npc_s      = pc_r + imm_j_s[ADDR_W-1:0];
                misalign_s = (npc_s[1:0] != 2'b00);
            end
`endif
            default: alu_s = 32'd0;
        endcase
    end

    // Writeback enable: only result-producing instructions, never x0
    always_comb begin
        case (opcode_s)
            OP_R, OP_I, OP_LW: wb_en_s = (rd_s != 5'd0);
`ifdef RV_MC_BRANCH_EN
            OP_JAL:            wb_en_s = (rd_s != 5'd0);
`endif
            default:           wb_en_s = 1'b0;
        endcase
    end

    // Next-state logic; an ack only counts while our request is up
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (mem_req_r && mem_ack) state_next_s = ST_DECODE;
                else                      state_next_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (dec_bad_s)        state_next_s = ST_ERR;
                else if (is_ebreak_s) state_next_s = ST_HALT;
                else                  state_next_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (misalign_s)              state_next_s = ST_ERR;
                else if (is_lw_s || is_sw_s) state_next_s = ST_MEM;
                else                         state_next_s = ST_WB;
            end
            ST_MEM: begin
                if (mem_req_r && mem_ack) state_next_s = ST_WB;
                else                      state_next_s = ST_MEM;
            end
            ST_WB:   state_next_s = ST_FETCH;
            ST_HALT: state_next_s = ST_HALT;
            ST_ERR:  state_next_s = ST_ERR;
            default: state_next_s = ST_ERR;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= ST_FETCH;
        else        state_r <= state_next_s;
    end

    // Datapath, register file and registered memory/status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r        <= RESET_PC;
            npc_r       <= RESET_PC;
            ir_r        <= 32'd0;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            res_r       <= 32'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'd0;
            retire_r    <= 1'b0;
            halted_r    <= 1'b0;
            illegal_r   <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf_r[i] <= 32'd0;
        end else begin
            retire_r  <= (state_next_s == ST_WB);
            halted_r  <= halted_r | (state_next_s == ST_HALT);
            illegal_r <= illegal_r | (state_next_s == ST_ERR);
            case (state_r)
                ST_FETCH: begin
                    if (!mem_req_r) begin
                        // first fetch after reset: raise the request one cycle late
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= pc_r;
                    end else if (mem_ack) begin
                        ir_r      <= mem_rdata;
                        mem_req_r <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    a_r <= rf_r[rs1_s[RIDX_W-1:0]];
                    b_r <= rf_r[rs2_s[RIDX_W-1:0]];
                end
                ST_EXEC: begin
                    res_r <= alu_s;
                    npc_r <= npc_s;
                    if (state_next_s == ST_MEM) begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= is_sw_s;
                        mem_addr_r <= ea_s;
                        if (is_sw_s) mem_wdata_r <= b_r;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        if (is_lw_s) res_r <= mem_rdata;
                    end
                end
                ST_WB: begin
                    if (wb_en_s) rf_r[rd_s[RIDX_W-1:0]] <= res_r;
                    pc_r       <= npc_r;
                    // request for the next fetch goes out as FETCH is entered
                    mem_req_r  <= 1'b1;
                    mem_we_r   <= 1'b0;
                    mem_addr_r <= npc_r;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign retire    = retire_r;
    assign halted    = halted_r;
    assign illegal   = illegal_r;

endmodule

// File: doc/rv_mc_core.md
Name: rv_mc_core

Overview:
- Synthesisable, parametrised multi-cycle RV32I-subset core; successor to the team's single-cycle simulation processor.
- Executes one instruction per pass through a fetch/decode/execute/memory/writeback state machine.
- Single shared request/acknowledge memory port for instruction and data accesses.
- Sits between a testbench or on-chip SRAM model and the debug harness, which watches the halt, illegal-instruction and retire outputs.

Parameters:
- ADDR_W, 12, byte-address width of the memory port; PC and effective addresses are truncated to this width.
- NREGS, 16, number of architectural registers; legal values are 16 (RV32E) or 32 (RV32I). x0 always reads 0.
- RESET_PC, 0, byte address of the first fetch after reset. Must be word aligned.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mem_req  out  1  memory request; held high until the acknowledge cycle.
- mem_we  out  1  1 = store, 0 = fetch or load.
- mem_addr  out  ADDR_W  byte address; bits [1:0] are always 0.
- mem_wdata  out  32  store data.
- mem_ack  in  1  completes the current request in the cycle it is sampled high together with mem_req.
- mem_rdata  in  32  read data; valid in the cycle mem_ack is high and mem_we=0.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  sticky; set by EBREAK.
- illegal  out  1  sticky; set by an unsupported encoding or a misaligned address.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=FETCH, PC=RESET_PC; IR and all registers = 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - retire=0, halted=0, illegal=0.
  - Reset mid-transaction abandons the transaction; mem_req drops on the next edge.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- FETCH:
  - Drive mem_req=1, mem_we=0, mem_addr=PC.
  - On mem_ack: IR <= mem_rdata, go to DECODE.
  - mem_ack may arrive in the same cycle mem_req first rises. Wait states are unbounded.
- DECODE:
  - Read rs1 and rs2.
  - Go to ERR if any of these hold:
    - opcode unsupported;
    - funct3/funct7 combination unsupported;
    - any register index >= NREGS.
  - EBREAK (0x00100073) goes to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: ADD, SUB, SLL, SRL, AND, OR. Shift amount = rs2[4:0]. SRL is logical.
  - I-type: ADDI, ANDI, ORI, with a 12-bit immediate sign-extended to 32 bits.
  - LW/SW effective address = rs1 + sign-extended I or S immediate, truncated to ADDR_W bits.
  - If EA[1:0] != 0, go to ERR. Otherwise LW/SW go to MEM; all other instructions go to WB.
- MEM:
  - Drive mem_req=1, mem_addr=EA; mem_we=1 for SW, with mem_wdata=rs2.
  - On mem_ack: latch load data and go to WB.
- WB:
  - Write the result to rd unless rd=0 or the instruction is SW.
  - PC <= PC+4, wrapping modulo 2^ADDR_W.
  - retire=1 for this cycle only, then go to FETCH.
- Latency with zero-wait memory:
  - ALU instructions: 4 cycles, FETCH to retire inclusive.
  - LW/SW: 5 cycles.
  - Each memory wait cycle adds 1.
- HALT: halted=1, mem_req=0. Stays until reset. No retire for EBREAK; PC keeps the EBREAK address.
- ERR: illegal=1, mem_req=0, no register write, PC unchanged. Stays until reset.
- Output timing and stability:
  - mem_addr, mem_we and mem_wdata are registered and stable while mem_req=1.
  - mem_ack while mem_req=0 is ignored.
- Writes to x0 are discarded. Arithmetic wraps modulo 2^32; no flags are produced.

Optional Feature:
- Macro: RV_MC_BRANCH_EN.
- With the macro defined, the core also decodes BEQ, BNE and JAL.
  - Branch targets are PC + sign-extended B immediate; JAL targets are PC + sign-extended J immediate.
  - A target with bits [1:0] != 0 goes to ERR.
  - The target is resolved in EXEC and applied in WB instead of PC+4.
  - JAL writes PC+4 to rd.
  - A not-taken branch behaves as PC+4; branches write no register.
  - Branches and JAL retire in 4 cycles.
- Without the macro, these opcodes go to ERR.

Test Plan:
- Basic ALU and load: program ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x1,x2; SW x3,0x40(x0); LW x5,0x40(x0); EBREAK, zero-wait memory.
  - Expect x3=2, x4=8, x5=2, mem[0x40]=2.
  - Expect 6 retire pulses, then halted=1 with PC=0x18.
- Memory wait states: same program with mem_ack delayed 3 cycles on every request.
  - Expect identical final state.
  - mem_addr, mem_we and mem_wdata never change while mem_req=1.
  - First retire lands 4+3 cycles after reset release.
- x0 and shifts: ADDI x0,x0,7; SLL x6,x1,x1 (x1=5); SRL x7,x6,x1.
  - Expect x0 reads 0, x6=0xA0, x7=5.
- Illegal decode: with NREGS=16, ADD x20,x1,x1.
  - Expect illegal=1, no retire, mem_req=0 thereafter.
  - LW with EA=0x42 also gives illegal=1.
- Reset mid-fetch: assert rst_n=0 for one cycle while mem_req=1 and mem_ack is still pending.
  - Next cycle: mem_req=0, PC=RESET_PC, all registers 0.
  - Then execution restarts cleanly.
- Branches (RV_MC_BRANCH_EN): BNE x1,x2,-8 loop with x1 decremented to 0.
  - Expect the loop to exit after 5 iterations.
  - JAL x1,+8 yields x1=PC+4, next fetch at PC+8.
  - Without the macro, the same program sets illegal=1.
